// File: rtl/mem_router_pkg.sv
// mem_router_pkg: shared FSM state type, control register layout and response codes. Rev 1.0
`default_nettype none

package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLV_REQ  = 2'd1,
    SLV_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam int CTRL_BOOT_BIT = 0;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_router_addr_decoder.sv
// mem_router_addr_decoder: base/mask region decode, lowest slave index wins, control register first. Rev 1.0
`default_nettype none

module mem_router_addr_decoder #(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE  = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK  = '0,
  parameter logic [ADDR_W-1:0]           CTRL_ADDR  = '1
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  ctrl_hit,
  output logic                  miss
);

  logic [NUM_SLAVES-1:0] raw_hit;
  logic                  found;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_region
    assign raw_hit[k] = (addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W];
  end

  assign ctrl_hit = (addr == CTRL_ADDR);
  assign miss     = !ctrl_hit && (raw_hit == '0);

  always_comb begin
    hit   = '0;
    found = ctrl_hit;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (raw_hit[k] && !found) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_router.sv
// mem_router: single-outstanding data-side router with watchdog, plus boot-register ROM/I$ select. Rev 1.0
`default_nettype none

module mem_router
  import mem_router_pkg::*;
#(
  parameter int                           NUM_SLAVES  = 4,
  parameter int                           ADDR_W      = 32,
  parameter int                           DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE    = {32'h8000_0000, 32'h2000_0000,
                                                         32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK    = {4{32'hF000_0000}},
  parameter logic [ADDR_W-1:0]            CTRL_ADDR   = 32'hFFFF_FFF0,
  parameter int                           TIMEOUT_CYC = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         core_req_i,
  input  logic                         core_we_i,
  input  logic [DATA_W/8-1:0]          core_be_i,
  input  logic [ADDR_W-1:0]            core_addr_i,
  input  logic [DATA_W-1:0]            core_wdata_i,
  output logic                         core_gnt_o,
  output logic                         core_rvalid_o,
  output logic [DATA_W-1:0]            core_rdata_o,
  output logic                         core_err_o,
  output logic [NUM_SLAVES-1:0]        slv_req_o,
  output logic                         slv_we_o,
  output logic [DATA_W/8-1:0]          slv_be_o,
  output logic [ADDR_W-1:0]            slv_addr_o,
  output logic [DATA_W-1:0]            slv_wdata_o,
  input  logic [NUM_SLAVES-1:0]        slv_gnt_i,
  input  logic [NUM_SLAVES-1:0]        slv_rvalid_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i,
  input  logic [31:0]                  rom_data_i,
  input  logic [31:0]                  icache_data_i,
  output logic [31:0]                  instr_data_o,
  output logic                         boot_sel_o
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  state_t                state, next_state;
  logic [NUM_SLAVES-1:0] dec_hit, sel;
  logic                  dec_ctrl, dec_miss, bad_req;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  timeout, sel_gnt, sel_rvalid, slv_done;
  logic                  boot_sel;
  logic [DATA_W-1:0]     rdata, slv_rdata;
  logic [1:0]            err_code;

  mem_router_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .CTRL_ADDR  (CTRL_ADDR)
  ) u_dec (
    .addr     (core_addr_i),
    .hit      (dec_hit),
    .ctrl_hit (dec_ctrl),
    .miss     (dec_miss)
  );

  assign bad_req    = dec_miss || (core_addr_i[1:0] != 2'b00) || (core_be_i == '0);
  assign cnt_nxt    = cnt + CNT_W'(1);
  assign timeout    = (cnt_nxt == CNT_W'(TIMEOUT_CYC));
  assign sel_gnt    = |(slv_gnt_i & sel);
  assign sel_rvalid = |(slv_rvalid_i & sel);
  // A response counts in SLV_REQ only when it comes together with the grant.
  assign slv_done   = sel_rvalid && ((state == SLV_WAIT) || sel_gnt);

  always_comb begin
    slv_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel[k]) slv_rdata = slv_rdata | slv_rdata_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    next_state    = state;
    core_gnt_o    = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    core_err_o    = 1'b0;
    slv_req_o     = '0;
    case (state)
      IDLE: begin
        core_gnt_o = core_req_i;
        if (core_req_i) next_state = (bad_req || dec_ctrl) ? RESP : SLV_REQ;
      end
      SLV_REQ: begin
        slv_req_o = sel;
        if (slv_done || timeout) next_state = RESP;
        else if (sel_gnt)        next_state = SLV_WAIT;
      end
      SLV_WAIT: begin
        if (slv_done || timeout) next_state = RESP;
      end
      RESP: begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = rdata;
        core_err_o    = (err_code != ERR_NONE);
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      boot_sel    <= 1'b1;
      rdata       <= '0;
      err_code    <= ERR_NONE;
      slv_we_o    <= 1'b0;
      slv_be_o    <= '0;
      slv_addr_o  <= '0;
      slv_wdata_o <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (core_req_i) begin
            slv_we_o    <= core_we_i;
            slv_be_o    <= core_be_i;
            slv_addr_o  <= core_addr_i;
            slv_wdata_o <= core_wdata_i;
            sel         <= bad_req ? '0 : dec_hit;
            cnt         <= '0;
            rdata       <= '0;
            err_code    <= bad_req ? ERR_DECODE : ERR_NONE;
            if (!bad_req && dec_ctrl) begin
              if (!core_we_i) rdata <= DATA_W'(boot_sel);
              else if (core_be_i[CTRL_BOOT_BIT/8]) boot_sel <= core_wdata_i[CTRL_BOOT_BIT];
            end
          end
        end
        SLV_REQ, SLV_WAIT: begin
          cnt <= cnt_nxt;
          if (slv_done) begin
            rdata    <= slv_we_o ? '0 : slv_rdata;
            err_code <= ERR_NONE;
          end else if (timeout) begin
            rdata    <= '0;
            err_code <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign boot_sel_o   = boot_sel;
  assign instr_data_o = boot_sel ? rom_data_i : icache_data_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_router.sv
// tb_mem_router: directed vector table plus hand-written timeout and reset sequences. Rev 1.0
`default_nettype none

module tb_mem_router;

  localparam logic [31:0] ROM_W = 32'h0000_0013;
  localparam logic [31:0] IC_W  = 32'h0010_0093;
  localparam logic [31:0] CTRL  = 32'hFFFF_FFF0;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         core_req_i = 1'b0;
  logic         core_we_i = 1'b0;
  logic [3:0]   core_be_i = '0;
  logic [31:0]  core_addr_i = '0;
  logic [31:0]  core_wdata_i = '0;
  logic         core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0]  core_rdata_o;
  logic [3:0]   slv_req_o;
  logic         slv_we_o;
  logic [3:0]   slv_be_o;
  logic [31:0]  slv_addr_o, slv_wdata_o;
  logic [3:0]   slv_gnt_i = '0;
  logic [3:0]   slv_rvalid_i = '0;
  logic [127:0] slv_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0A0A_0000};
  logic [31:0]  rom_data_i = ROM_W;
  logic [31:0]  icache_data_i = IC_W;
  logic [31:0]  instr_data_o;
  logic         boot_sel_o;

  int checks = 0;
  int failures = 0;

  mem_router dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .core_req_i    (core_req_i),
    .core_we_i     (core_we_i),
    .core_be_i     (core_be_i),
    .core_addr_i   (core_addr_i),
    .core_wdata_i  (core_wdata_i),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .core_err_o    (core_err_o),
    .slv_req_o     (slv_req_o),
    .slv_we_o      (slv_we_o),
    .slv_be_o      (slv_be_o),
    .slv_addr_o    (slv_addr_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_gnt_i     (slv_gnt_i),
    .slv_rvalid_i  (slv_rvalid_i),
    .slv_rdata_i   (slv_rdata_i),
    .rom_data_i    (rom_data_i),
    .icache_data_i (icache_data_i),
    .instr_data_o  (instr_data_o),
    .boot_sel_o    (boot_sel_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gnt_d;
    int          rv_d;
    logic [3:0]  noise;
    logic [3:0]  exp_req;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_boot;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (case %0d): got %08h expected %08h", name, id, act, exp);
    end
  endtask

  task automatic next_slot();
    @(posedge clk_i);
    #2;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  idx;
    bit  seen;
    idx = -1;
    for (int k = 0; k < 4; k++) if (v.exp_req[k]) idx = k;
    core_req_i   = 1'b1;
    core_we_i    = v.we;
    core_be_i    = v.be;
    core_addr_i  = v.addr;
    core_wdata_i = v.wdata;
    slv_gnt_i    = '0;
    slv_rvalid_i = '0;
    #1 chk("core_gnt", id, 32'(core_gnt_o), 32'd1);
    next_slot();
    core_req_i = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 300 && !seen; n++) begin
      slv_gnt_i    = '0;
      slv_rvalid_i = '0;
      if (idx >= 0) begin
        if (n == v.gnt_d) slv_gnt_i[idx] = 1'b1;
        if (n == v.rv_d)  slv_rvalid_i[idx] = 1'b1;
      end
      if (n == 1) begin
        slv_gnt_i    = slv_gnt_i | v.noise;
        slv_rvalid_i = slv_rvalid_i | v.noise;
      end
      #1;
      chk("slv_req", id, 32'(slv_req_o), (n <= v.gnt_d) ? 32'(v.exp_req) : 32'd0);
      if (n <= v.gnt_d) begin
        chk("slv_addr", id, slv_addr_o, v.addr);
        chk("slv_we", id, 32'(slv_we_o), 32'(v.we));
        chk("slv_be", id, 32'(slv_be_o), 32'(v.be));
        chk("slv_wdata", id, slv_wdata_o, v.wdata);
      end
      if (core_rvalid_o) begin
        seen = 1'b1;
        chk("latency", id, 32'(n), 32'(v.exp_lat));
        chk("rdata", id, core_rdata_o, v.exp_rdata);
        chk("err", id, 32'(core_err_o), 32'(v.exp_err));
        chk("boot_sel", id, 32'(boot_sel_o), 32'(v.exp_boot));
        chk("instr", id, instr_data_o, v.exp_boot ? ROM_W : IC_W);
      end
      next_slot();
    end
    if (!seen) chk("rsp_missing", id, 32'd0, 32'd1);
    slv_gnt_i    = '0;
    slv_rvalid_i = '0;
    #1 chk("rvalid_pulse", id, 32'(core_rvalid_o), 32'd0);
  endtask

  initial begin
    bit seen;
    //            addr          we    be       wdata          gnt rv noise    req      rdata          err  lat boot
    vecs[0]  = '{32'h1000_0008, 1'b0, 4'b1111, 32'h0,          2, 3, 4'b0001, 4'b0010, 32'hDEAD_BEEF, 1'b0, 4, 1'b1};
    vecs[1]  = '{32'h2000_0010, 1'b1, 4'b0011, 32'h1234_5678,  1, 1, 4'b0000, 4'b0100, 32'h0,         1'b0, 2, 1'b1};
    vecs[2]  = '{32'h0000_0004, 1'b0, 4'b1111, 32'h0,          1, 2, 4'b1000, 4'b0001, 32'h0A0A_0000, 1'b0, 3, 1'b1};
    vecs[3]  = '{32'h8000_00FC, 1'b0, 4'b1100, 32'h0,          3, 3, 4'b0000, 4'b1000, 32'h3333_3333, 1'b0, 4, 1'b1};
    vecs[4]  = '{32'h5000_0000, 1'b0, 4'b1111, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b1, 1, 1'b1};
    vecs[5]  = '{32'h1000_0002, 1'b0, 4'b1111, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b1, 1, 1'b1};
    vecs[6]  = '{32'h2000_0000, 1'b0, 4'b0000, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b1, 1, 1'b1};
    vecs[7]  = '{CTRL,          1'b1, 4'b0001, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b0, 1, 1'b0};
    vecs[8]  = '{CTRL,          1'b0, 4'b1111, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b0, 1, 1'b0};
    vecs[9]  = '{CTRL,          1'b1, 4'b0010, 32'h1,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b0, 1, 1'b0};
    vecs[10] = '{CTRL,          1'b0, 4'b1111, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b0, 1, 1'b0};
    vecs[11] = '{CTRL,          1'b1, 4'b0001, 32'h1,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b0, 1, 1'b1};
    vecs[12] = '{CTRL,          1'b0, 4'b1111, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h1,         1'b0, 1, 1'b1};
    vecs[13] = '{CTRL,          1'b1, 4'b0001, 32'h0,          0, 0, 4'b0000, 4'b0000, 32'h0,         1'b0, 1, 1'b0};

    // Reset values while rst_ni is held low.
    next_slot();
    #1;
    chk("rst_boot_sel", -1, 32'(boot_sel_o), 32'd1);
    chk("rst_instr", -1, instr_data_o, ROM_W);
    chk("rst_slv_req", -1, 32'(slv_req_o), 32'd0);
    chk("rst_slv_addr", -1, slv_addr_o, 32'd0);
    chk("rst_rvalid", -1, 32'(core_rvalid_o), 32'd0);
    chk("rst_err", -1, 32'(core_err_o), 32'd0);
    chk("rst_rdata", -1, core_rdata_o, 32'd0);
    chk("rst_gnt", -1, 32'(core_gnt_o), 32'd0);
    rst_ni = 1'b1;
    next_slot();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Slave 3 never grants: watchdog fires 255 cycles after entering SLV_REQ.
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_be_i   = 4'b1111;
    core_addr_i = 32'h8000_0000;
    #1 chk("to_gnt", 100, 32'(core_gnt_o), 32'd1);
    next_slot();
    core_req_i = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 300 && !seen; n++) begin
      #1;
      if (core_rvalid_o) begin
        seen = 1'b1;
        chk("to_latency", 100, 32'(n), 32'd256);
        chk("to_err", 100, 32'(core_err_o), 32'd1);
        chk("to_rdata", 100, core_rdata_o, 32'd0);
        chk("to_slv_req_after", 100, 32'(slv_req_o), 32'd0);
      end else if (n == 1 || n == 255) begin
        chk("to_slv_req", 100, 32'(slv_req_o), 32'b1000);
      end
      next_slot();
    end
    if (!seen) chk("to_rsp_missing", 100, 32'd0, 32'd1);
    slv_gnt_i[3]    = 1'b1;
    slv_rvalid_i[3] = 1'b1;
    #1 chk("stale_rvalid", 101, 32'(core_rvalid_o), 32'd0);
    next_slot();
    slv_gnt_i    = '0;
    slv_rvalid_i = '0;
    #1;
    chk("stale_rvalid_next", 101, 32'(core_rvalid_o), 32'd0);
    chk("stale_slv_req", 101, 32'(slv_req_o), 32'd0);
    next_slot();

    // Reset dropped while the transaction sits in SLV_WAIT.
    core_req_i  = 1'b1;
    core_addr_i = 32'h1000_0000;
    next_slot();
    core_req_i   = 1'b0;
    slv_gnt_i[1] = 1'b1;
    next_slot();
    slv_gnt_i = '0;
    #1 chk("mid_boot_pre", 102, 32'(boot_sel_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rvalid", 102, 32'(core_rvalid_o), 32'd0);
    chk("mid_boot_sel", 102, 32'(boot_sel_o), 32'd1);
    chk("mid_slv_req", 102, 32'(slv_req_o), 32'd0);
    slv_rvalid_i[1] = 1'b1;
    next_slot();
    chk("mid_rvalid_held", 102, 32'(core_rvalid_o), 32'd0);
    rst_ni       = 1'b1;
    slv_rvalid_i = '0;
    next_slot();
    #1 chk("mid_rvalid_post", 102, 32'(core_rvalid_o), 32'd0);
    core_req_i  = 1'b1;
    core_addr_i = 32'h5000_0000;
    #1 chk("mid_idle_gnt", 102, 32'(core_gnt_o), 32'd1);
    core_req_i = 1'b0;
    next_slot();
    #1 chk("mid_no_rsp", 102, 32'(core_rvalid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
